// File: rtl/lsu_mem_stage.sv
// Load/store unit memory stage. Each request from the core becomes at most one
// data-memory transaction on a req/gnt/rvalid bus. Stores get byte enables and
// lane-replicated data. Loads are extracted and extended before writeback.
// Bad accesses and bus timeouts retire with an error flag and no load data.
module lsu_mem_stage #(
  parameter int RSP_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_zext_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_stall_o,
  output logic        lsu_done_o,
  output logic        lsu_err_o,
  output logic [31:0] lsu_rdata_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  // Counter only needs to reach RSP_TIMEOUT-1; a zero timeout disables it.
  localparam int CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0);
  localparam bit TO_EN = (RSP_TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              accept;

  logic [31:0]       addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              zext_q;
  logic [1:0]        off_q;

  logic              timeout_hit;

  // Half needs even address, word needs 4-byte alignment, size 11 is never legal.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the significant low bytes so every enabled lane sees the right data.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [1:0] size, input logic zext,
                                           input logic [1:0] off, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{off, 3'b000} +: 8];
    h = rd[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   return zext ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return zext ? {16'd0, h} : {{16{h[15]}}, h};
      default: return rd;
    endcase
  endfunction

  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  // State register and control state; reset aborts any transaction silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Request fields latched at accept; formatted result latched on the way to DONE.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= {lsu_addr_i[31:2], 2'b00};
      we_q    <= lsu_we_i;
      be_q    <= gen_be(lsu_size_i, lsu_addr_i[1:0]);
      wdata_q <= lane_wdata(lsu_size_i, lsu_wdata_i);
      size_q  <= lsu_size_i;
      zext_q  <= lsu_zext_i;
      off_q   <= lsu_addr_i[1:0];
    end
    rdata_q <= rdata_d;
  end

  // Next-state logic; a response arriving on the last counted cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (lsu_req_i) begin
          err_d   = access_bad(lsu_size_i, lsu_addr_i[1:0]);
          rdata_d = '0;
          cnt_d   = '0;
          if (access_bad(lsu_size_i, lsu_addr_i[1:0])) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
            accept  = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt_i) begin
          state_d = we_q ? S_DONE : S_WAIT;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = S_DONE;
          rdata_d = fmt_load(size_q, zext_q, off_q, dmem_rdata_i);
        end else if (timeout_hit) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: bus fields only while requesting, results only in the retire cycle.
  always_comb begin
    lsu_stall_o  = 1'b0;
    lsu_done_o   = 1'b0;
    lsu_err_o    = 1'b0;
    lsu_rdata_o  = '0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = '0;
    dmem_be_o    = '0;
    dmem_wdata_o = '0;
    case (state_q)
      S_IDLE: lsu_stall_o = lsu_req_i;
      S_REQ: begin
        lsu_stall_o  = 1'b1;
        dmem_req_o   = 1'b1;
        dmem_we_o    = we_q;
        dmem_addr_o  = addr_q;
        dmem_be_o    = be_q;
        dmem_wdata_o = wdata_q;
      end
      S_WAIT: lsu_stall_o = 1'b1;
      default: begin
        lsu_done_o  = 1'b1;
        lsu_err_o   = err_q;
        lsu_rdata_o = rdata_q;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: one default instance plus one with a short
// response timeout, both driven from the same stimulus.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, zext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid;
  logic [31:0] mrdata;

  logic        a_stall, a_done, a_err, a_dreq, a_dwe;
  logic [31:0] a_rdata, a_daddr, a_dwdata;
  logic [3:0]  a_dbe;
  logic        t_stall, t_done, t_err, t_dreq, t_dwe;
  logic [31:0] t_rdata, t_daddr, t_dwdata;
  logic [3:0]  t_dbe;

  bit          use_to = 1'b0;
  logic        o_stall, o_done, o_err, o_dreq, o_dwe;
  logic [31:0] o_rdata, o_daddr, o_dwdata;
  logic [3:0]  o_dbe;

  assign o_stall  = use_to ? t_stall  : a_stall;
  assign o_done   = use_to ? t_done   : a_done;
  assign o_err    = use_to ? t_err    : a_err;
  assign o_rdata  = use_to ? t_rdata  : a_rdata;
  assign o_dreq   = use_to ? t_dreq   : a_dreq;
  assign o_dwe    = use_to ? t_dwe    : a_dwe;
  assign o_daddr  = use_to ? t_daddr  : a_daddr;
  assign o_dbe    = use_to ? t_dbe    : a_dbe;
  assign o_dwdata = use_to ? t_dwdata : a_dwdata;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk(clk), .reset(reset),
    .lsu_req_i(req), .lsu_we_i(we), .lsu_size_i(size), .lsu_zext_i(zext),
    .lsu_addr_i(addr), .lsu_wdata_i(wdata),
    .lsu_stall_o(a_stall), .lsu_done_o(a_done), .lsu_err_o(a_err), .lsu_rdata_o(a_rdata),
    .dmem_req_o(a_dreq), .dmem_we_o(a_dwe), .dmem_addr_o(a_daddr), .dmem_be_o(a_dbe),
    .dmem_wdata_o(a_dwdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(mrdata)
  );

  lsu_mem_stage #(.RSP_TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset),
    .lsu_req_i(req), .lsu_we_i(we), .lsu_size_i(size), .lsu_zext_i(zext),
    .lsu_addr_i(addr), .lsu_wdata_i(wdata),
    .lsu_stall_o(t_stall), .lsu_done_o(t_done), .lsu_err_o(t_err), .lsu_rdata_o(t_rdata),
    .dmem_req_o(t_dreq), .dmem_we_o(t_dwe), .dmem_addr_o(t_daddr), .dmem_be_o(t_dbe),
    .dmem_wdata_o(t_dwdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(mrdata)
  );

  int vectors = 0;
  int miscompares = 0;

  int          r_done_cyc, r_ndone, r_nreq, r_stall_bad;
  logic        r_err, r_we;
  logic [31:0] r_rd, r_a, r_wd;
  logic [3:0]  r_be;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    req = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drives one request; gnt after gnt_dly REQ cycles, rvalid rv_dly cycles after gnt.
  task automatic run_op(input logic op_we, input logic [1:0] op_size, input logic op_zext,
                        input logic [31:0] op_addr, input logic [31:0] op_wdata,
                        input int gnt_dly, input int rv_dly, input logic [31:0] mem_word);
    int req_cyc;
    int rv_cnt;
    bit granted;
    bit fin;
    r_done_cyc = -1; r_ndone = 0; r_nreq = 0; r_stall_bad = 0;
    r_err = 1'b0; r_we = 1'b0; r_rd = '0; r_a = '0; r_wd = '0; r_be = '0;
    req_cyc = 0; rv_cnt = 0; granted = 1'b0; fin = 1'b0;
    req = 1'b1; we = op_we; size = op_size; zext = op_zext;
    addr = op_addr; wdata = op_wdata; mrdata = mem_word;
    for (int c = 0; c < 40 && !fin; c++) begin
      gnt    = o_dreq && (req_cyc == gnt_dly);
      rvalid = granted && !op_we && (rv_cnt == rv_dly);
      @(negedge clk);
      if (o_dreq) begin
        r_nreq++;
        r_a = o_daddr; r_be = o_dbe; r_wd = o_dwdata; r_we = o_dwe;
      end
      if (o_done) begin
        r_ndone++; r_done_cyc = c; r_err = o_err; r_rd = o_rdata; fin = 1'b1;
        if (o_stall) r_stall_bad++;
      end else if (!o_stall) begin
        r_stall_bad++;
      end
      if (o_dreq) begin
        if (gnt) granted = 1'b1;
        req_cyc++;
      end
      if (granted) rv_cnt++;
      @(posedge clk); #1;
    end
    req = 1'b0; gnt = 1'b0; rvalid = 1'b0;
  endtask

  task automatic chk_ret(input string t, input int cyc, input logic err, input logic [31:0] rd);
    chk({t, ".ndone"}, r_ndone, 1);
    chk({t, ".cyc"}, r_done_cyc, cyc);
    chk({t, ".err"}, r_err, err);
    chk({t, ".rdata"}, r_rd, rd);
    chk({t, ".stall"}, r_stall_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; zext = 1'b0;
    addr = '0; wdata = '0; gnt = 1'b0; rvalid = 1'b0; mrdata = '0;
    #1;
    chk("rst.stall", a_stall, 0);
    chk("rst.done", {a_done, a_err, a_dreq, a_dwe}, 0);
    chk("rst.rdata", a_rdata, 0);
    chk("rst.daddr", a_daddr, 0);
    chk("rst.be_wd", {a_dbe, a_dwdata[27:0]}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // SW word aligned
    run_op(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 0, 1, 32'h0);
    chk_ret("sw", 2, 1'b0, 32'h0);
    chk("sw.nreq", r_nreq, 1);
    chk("sw.addr", r_a, 32'h104);
    chk("sw.be", r_be, 4'b1111);
    chk("sw.wdata", r_wd, 32'hDEADBEEF);
    chk("sw.we", r_we, 1'b1);

    // SB to top lane
    run_op(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5, 0, 1, 32'h0);
    chk_ret("sb", 2, 1'b0, 32'h0);
    chk("sb.addr", r_a, 32'h100);
    chk("sb.be", r_be, 4'b1000);
    chk("sb.wdata", r_wd, 32'hA5A5A5A5);

    // SH to upper half
    run_op(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 0, 1, 32'h0);
    chk("sh.be", r_be, 4'b1100);
    chk("sh.wdata", r_wd, 32'hABCDABCD);

    // LB / LBU lane 2
    run_op(1'b0, 2'b00, 1'b0, 32'h102, 32'hDEADBEEF, 0, 1, 32'h12F03456);
    chk_ret("lb", 3, 1'b0, 32'hFFFFFFF0);
    chk("lb.be", r_be, 4'b0100);
    chk("lb.we", r_we, 1'b0);
    run_op(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 0, 1, 32'h12F03456);
    chk_ret("lbu", 3, 1'b0, 32'h000000F0);

    // LH upper half positive, lower half negative
    run_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 1, 32'h12F03456);
    chk("lh_hi.rdata", r_rd, 32'h000012F0);
    run_op(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 0, 1, 32'h00008001);
    chk("lh_lo.rdata", r_rd, 32'hFFFF8001);
    chk("lh_lo.be", r_be, 4'b0011);
    run_op(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 0, 1, 32'h00008001);
    chk("lhu.rdata", r_rd, 32'h00008001);

    // Bad accesses: no bus traffic, done at c1 with err
    run_op(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 0, 1, 32'hFFFFFFFF);
    chk_ret("lh_mis", 1, 1'b1, 32'h0);
    chk("lh_mis.nreq", r_nreq, 0);
    run_op(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, 1, 32'hFFFFFFFF);
    chk_ret("lw_mis", 1, 1'b1, 32'h0);
    chk("lw_mis.nreq", r_nreq, 0);
    run_op(1'b1, 2'b11, 1'b0, 32'h100, 32'h0, 0, 1, 32'hFFFFFFFF);
    chk_ret("sz11", 1, 1'b1, 32'h0);
    chk("sz11.nreq", r_nreq, 0);

    // Slow memory: gnt after 3 REQ cycles, rvalid 2 cycles after gnt
    run_op(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 3, 2, 32'hCAFEF00D);
    chk_ret("lw_slow", 7, 1'b0, 32'hCAFEF00D);
    chk("lw_slow.nreq", r_nreq, 4);

    // Timeout instance: no gnt -> err after 4 REQ cycles
    use_to = 1'b1;
    run_op(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1000, 1, 32'h55555555);
    chk_ret("to_req", 5, 1'b1, 32'h0);
    chk("to_req.nreq", r_nreq, 4);
    do_reset();
    @(posedge clk); #1;
    // gnt on the last counted cycle wins
    run_op(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 3, 1, 32'h0BADF00D);
    chk_ret("to_gnt_win", 6, 1'b0, 32'h0BADF00D);
    // rvalid on the last counted WAIT cycle wins
    run_op(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 0, 4, 32'h76543210);
    chk_ret("to_rv_win", 6, 1'b0, 32'h76543210);
    // timeout in WAIT
    run_op(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 0, 1000, 32'h76543210);
    chk_ret("to_wait", 6, 1'b1, 32'h0);
    // stale rvalid after timeout is ignored
    rvalid = 1'b1;
    @(negedge clk);
    chk("to_stale.done", {t_done, t_stall}, 0);
    @(posedge clk); #1 rvalid = 1'b0;
    @(negedge clk);
    chk("to_stale.done2", t_done, 0);
    use_to = 1'b0;
    @(posedge clk); #1;

    // Reset while waiting for read data
    req = 1'b1; we = 1'b0; size = 2'b10; zext = 1'b0; addr = 32'h400; gnt = 1'b0;
    @(posedge clk); #1 gnt = 1'b1;
    @(negedge clk);
    chk("rstw.req", a_dreq, 1);
    @(posedge clk); #1 gnt = 1'b0;
    @(negedge clk);
    chk("rstw.wait", {a_stall, a_dreq}, 2'b10);
    #1 reset = 1'b1; req = 1'b0;
    #1;
    chk("rstw.ctl", {a_stall, a_done, a_err, a_dreq, a_dwe}, 0);
    chk("rstw.rdata", a_rdata, 0);
    @(posedge clk); #1 reset = 1'b0; rvalid = 1'b1; mrdata = 32'hDEADDEAD;
    @(negedge clk);
    chk("rstw.stale", {a_done, a_stall, a_dreq}, 0);
    @(posedge clk); #1 rvalid = 1'b0;
    @(negedge clk);
    chk("rstw.stale2", {a_done, a_stall}, 0);
    @(posedge clk); #1;
    run_op(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 0, 1, 32'h11223344);
    chk_ret("lw_after", 3, 1'b0, 32'h11223344);
    chk("lw_after.addr", r_a, 32'h104);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
